// File: rtl/vblank_task_scheduler.sv
// ----------------------------------------------------------------------------
// vblank_task_scheduler
//
// Per-frame game-logic sequencer. A falling edge on the active-low vsync
// starts a sequence that grants each enabled task an exclusive update slot,
// in fixed index order, so all game-state updates land inside blanking.
// Frame overrun (a new vsync while still sequencing) and hung tasks (watchdog)
// are reported through sticky flags.
//
// Optional feature macro: VBS_WATCHDOG_EN
//   defined     : per-task watchdog; a task that does not ack within TIMEOUT
//                 cycles of WAIT is released and timeout_err is set.
//   not defined : no watchdog counter; WAIT lasts until ack; timeout_err = 0.
//
// Ports
//   clk         pixel clock
//   clr         asynchronous active-high reset
//   vga_VS      vsync from the timing generator, active-low
//   pause       1 = ignore new frame triggers (only looked at in IDLE)
//   task_en     per-task enable, sampled in the task's SLOT cycle
//   task_ack    task done; only bit cur_task is honoured, and only in WAIT
//   clear_err   1-cycle pulse clearing overrun/timeout_err (a same-cycle set wins)
//   task_req    one-hot update grant
//   cur_task    index of the task being served (holds last value in IDLE)
//   frame_tick  1-cycle pulse at the start of each accepted sequence
//   seq_done    1-cycle pulse after the last task
//   busy        high whenever the sequencer is not IDLE
//   frame_cnt   accepted sequences, wraps 0xFFFF -> 0
//   overrun     sticky: trigger arrived while busy
//   timeout_err sticky: a task timed out
//
// Handshake: task_req[i] rises when task i enters WAIT and stays high until the
// clock edge at which task_ack[i] is sampled high (or the watchdog fires); it
// falls on that edge. The task may hold ack longer; it is ignored outside WAIT.
// ----------------------------------------------------------------------------
module vblank_task_scheduler #(
  parameter int N_TASKS = 4,
  parameter int TIMEOUT = 20000,
  parameter int TMO_W   = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               vga_VS,
  input  logic               pause,
  input  logic [N_TASKS-1:0] task_en,
  input  logic [N_TASKS-1:0] task_ack,
  input  logic               clear_err,
  output logic [N_TASKS-1:0] task_req,
  output logic [2:0]         cur_task,
  output logic               frame_tick,
  output logic               seq_done,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic               overrun,
  output logic               timeout_err
);

  if (N_TASKS < 1 || N_TASKS > 8) begin : g_bad_tasks
    $error("vblank_task_scheduler: N_TASKS must be in 1..8");
  end
  if (TIMEOUT < 1 || 64'(TIMEOUT) >= (64'd1 << TMO_W)) begin : g_bad_timeout
    $error("vblank_task_scheduler: TIMEOUT must be >= 1 and fit in TMO_W bits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_TICK,
    S_SLOT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic               vs_d;
  logic               trig;
  logic [N_TASKS-1:0] sel;
  logic               en_cur;
  logic               ack_cur;
  logic               last_task;
  logic               wd_fire;
  logic [N_TASKS-1:0] req_n;
  logic [2:0]         cur_n;
  logic [15:0]        cnt_n;
  logic               ovr_n;

  // Start of vsync: previous sample high, current sample low.
  assign trig = vs_d & ~vga_VS;

  // Decode the served index once; enable/ack/grant all use it.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_TASKS; i++) begin
      sel[i] = (cur_task == 3'(i));
    end
  end

  assign en_cur    = |(task_en & sel);
  assign ack_cur   = |(task_ack & sel);
  assign last_task = (cur_task == 3'(N_TASKS - 1));

`ifdef VBS_WATCHDOG_EN
  logic [TMO_W-1:0] tmo, tmo_n;
  logic             terr_n;

  // Fires on the TIMEOUT-th WAIT cycle; a same-cycle ack takes precedence.
  assign wd_fire = (tmo == TMO_W'(TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_n = state;
    req_n   = task_req;
    cur_n   = cur_task;
    cnt_n   = frame_cnt;
    ovr_n   = overrun & ~clear_err;
`ifdef VBS_WATCHDOG_EN
    tmo_n   = tmo;
    terr_n  = timeout_err & ~clear_err;
`endif

    // Any trigger outside IDLE (DONE included) is dropped and flagged.
    if (trig && state != S_IDLE) begin
      ovr_n = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (trig && !pause) begin
          state_n = S_TICK;
          cnt_n   = frame_cnt + 16'd1;
          cur_n   = 3'd0;
        end
      end
      S_TICK: begin
        state_n = S_SLOT;
      end
      S_SLOT: begin
        if (en_cur) begin
          req_n   = sel;
          state_n = S_WAIT;
`ifdef VBS_WATCHDOG_EN
          tmo_n   = '0;
`endif
        end else if (last_task) begin
          state_n = S_DONE;
        end else begin
          cur_n   = cur_task + 3'd1;
        end
      end
      S_WAIT: begin
`ifdef VBS_WATCHDOG_EN
        tmo_n = tmo + TMO_W'(1);
        if (!ack_cur && wd_fire) begin
          terr_n = 1'b1;
        end
`endif
        if (ack_cur || wd_fire) begin
          req_n = '0;
          if (last_task) begin
            state_n = S_DONE;
          end else begin
            cur_n   = cur_task + 3'd1;
            state_n = S_SLOT;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= S_IDLE;
      vs_d       <= 1'b1;
      task_req   <= '0;
      cur_task   <= 3'd0;
      frame_tick <= 1'b0;
      seq_done   <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 16'd0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      vs_d       <= vga_VS;
      task_req   <= req_n;
      cur_task   <= cur_n;
      frame_tick <= (state_n == S_TICK);
      seq_done   <= (state_n == S_DONE);
      busy       <= (state_n != S_IDLE);
      frame_cnt  <= cnt_n;
      overrun    <= ovr_n;
    end
  end

`ifdef VBS_WATCHDOG_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tmo         <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo         <= tmo_n;
      timeout_err <= terr_n;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_vblank_task_scheduler.sv
// ----------------------------------------------------------------------------
// tb_vblank_task_scheduler
//
// Bench for vblank_task_scheduler (N_TASKS=4, TIMEOUT=8). A timeline model
// expands each accepted frame into its expected per-cycle outputs (TICK, one
// SLOT per task, ack-delay WAIT cycles for enabled tasks, DONE) and a compare
// process checks every DUT output on each falling clock edge. A grant-order
// scoreboard (exp_q) and literal checks after the directed tests pin the model.
// ----------------------------------------------------------------------------
module tb_vblank_task_scheduler;
  localparam int N   = 4;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         vga_VS = 1'b1;
  logic         pause = 1'b0;
  logic         clear_err = 1'b0;
  logic [N-1:0] task_en = '0;
  logic [N-1:0] task_ack = '0;
  logic [N-1:0] task_req;
  logic [2:0]   cur_task;
  logic         frame_tick, seq_done, busy, overrun, timeout_err;
  logic [15:0]  frame_cnt;

  always #5 clk = ~clk;

  vblank_task_scheduler #(.N_TASKS(N), .TIMEOUT(TMO), .TMO_W(16)) dut (
    .clk(clk), .clr(clr), .vga_VS(vga_VS), .pause(pause), .task_en(task_en),
    .task_ack(task_ack), .clear_err(clear_err), .task_req(task_req),
    .cur_task(cur_task), .frame_tick(frame_tick), .seq_done(seq_done),
    .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit           busy;
    bit           tick;
    bit           done;
    logic [N-1:0] req;
    logic [2:0]   cur;
    bit           terr_set;   // timeout_err becomes set at the start of this cycle
  } rec_t;

  rec_t        tl_q[$];       // expected outputs for the cycles still to come
  rec_t        exp_r;         // expected outputs for the current cycle
  logic [2:0]  exp_q[$];      // expected grant order
  logic [15:0] m_cnt;
  bit          m_ovr, m_terr, vs_prev;
  int          dly[N];        // ack delay per task (cycles of req before ack)

  function automatic rec_t mk(bit b, bit t, bit d, logic [N-1:0] r, logic [2:0] c, bit ts);
    rec_t x;
    x.busy = b; x.tick = t; x.done = d; x.req = r; x.cur = c; x.terr_set = ts;
    return x;
  endfunction

  task automatic model_reset();
    tl_q.delete();
    exp_q.delete();
    exp_r   = mk(0, 0, 0, '0, 3'd0, 0);
    m_cnt   = 16'd0;
    m_ovr   = 0;
    m_terr  = 0;
    vs_prev = 1;
  endtask

  task automatic build_frame();
    bit pend;
    int w;
    pend = 0;
    tl_q.push_back(mk(1, 1, 0, '0, 3'd0, 0));
    for (int i = 0; i < N; i++) begin
      tl_q.push_back(mk(1, 0, 0, '0, 3'(i), pend));
      pend = 0;
      if (task_en[i]) begin
        exp_q.push_back(3'(i));
        w = dly[i];
`ifdef VBS_WATCHDOG_EN
        if (w > TMO) begin
          w    = TMO;
          pend = 1;
        end
`endif
        for (int k = 0; k < w; k++)
          tl_q.push_back(mk(1, 0, 0, N'(1) << i, 3'(i), 0));
      end
    end
    tl_q.push_back(mk(1, 0, 1, '0, 3'(N - 1), pend));
  endtask

  task automatic model_step();
    bit   trig, busy_prev;
    rec_t r;
    trig      = vs_prev && !vga_VS;
    vs_prev   = vga_VS;
    busy_prev = exp_r.busy;
    if (clear_err) begin
      m_ovr  = 0;
      m_terr = 0;
    end
    if (trig) begin
      if (busy_prev) m_ovr = 1;
      else if (!pause) begin
        build_frame();
        m_cnt = m_cnt + 16'd1;
      end
    end
    if (tl_q.size() > 0) r = tl_q.pop_front();
    else r = mk(0, 0, 0, '0, exp_r.cur, 0);
    if (r.terr_set) m_terr = 1;
    exp_r = r;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge clr);
      if (clr) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare + grant scoreboard ----------------
  logic [2:0]   obs_q[$];
  logic [N-1:0] prev_req = '0;
  int           ticks = 0, dones = 0, hi2 = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (clr) begin
        check("rst_req", 32'(task_req), 0);
        check("rst_cur", 32'(cur_task), 0);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_done", 32'(seq_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_terr", 32'(timeout_err), 0);
      end else begin
        check("task_req", 32'(task_req), 32'(exp_r.req));
        check("cur_task", 32'(cur_task), 32'(exp_r.cur));
        check("frame_tick", 32'(frame_tick), 32'(exp_r.tick));
        check("seq_done", 32'(seq_done), 32'(exp_r.done));
        check("busy", 32'(busy), 32'(exp_r.busy));
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (task_req != '0 && task_req != prev_req) begin
          logic [2:0] idx;
          idx = 3'd0;
          for (int i = 0; i < N; i++) if (task_req[i]) idx = 3'(i);
          obs_q.push_back(idx);
          if (exp_q.size() == 0) check("grant_unexpected", 32'(idx), 32'hFF);
          else check("grant_order", 32'(idx), 32'(exp_q.pop_front()));
        end
        ticks += int'(frame_tick);
        dones += int'(seq_done);
        hi2   += int'(task_req[2]);
      end
      prev_req = task_req;
    end
  end

  // ---------------- task responder ----------------
  bit noise_en = 1;
  int rc[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      rc[i]  = 0;
      dly[i] = 2;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (task_req[i]) begin
          rc[i]++;
          task_ack[i] = (rc[i] >= dly[i]);
        end else begin
          rc[i]       = 0;
          task_ack[i] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_fall();
    @(negedge clk);
    vga_VS = 1'b0;
    cycles(2);
    vga_VS = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (exp_r.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_r.busy) check({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic set_frame(input logic [N-1:0] en, input int d);
    task_en = en;
    for (int i = 0; i < N; i++) dly[i] = d;
    obs_q.delete();
    ticks = 0;
    dones = 0;
    hi2   = 0;
  endtask

  task automatic check_order(input string name, input int n, input logic [2:0] a0,
                             input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] a3);
    logic [2:0] lit[4];
    lit[0] = a0; lit[1] = a1; lit[2] = a2; lit[3] = a3;
    check({name, "_ngrants"}, 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++)
      check({name, "_grant"}, 32'(obs_q[i]), 32'(lit[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset with random inputs, then release with no vsync edge.
    repeat (6) begin
      @(negedge clk);
      vga_VS    = 1'($urandom_range(0, 1));
      pause     = 1'($urandom_range(0, 1));
      clear_err = 1'($urandom_range(0, 1));
      task_en   = N'($urandom_range(0, 15));
    end
    @(negedge clk);
    vga_VS = 1'b1; pause = 1'b0; clear_err = 1'b0; noise_en = 0;
    clr = 1'b0;
    cycles(8);
    check("idle_busy", 32'(busy), 0);
    check("idle_cnt", 32'(frame_cnt), 0);

    // 2: all tasks enabled, ack two cycles after req.
    set_frame(4'hF, 2);
    vs_fall();
    wait_idle("t2", 100);
    cycles(2);
    check("t2_cnt", 32'(frame_cnt), 1);
    check("t2_busy", 32'(busy), 0);
    check("t2_ticks", 32'(ticks), 1);
    check("t2_dones", 32'(dones), 1);
    check_order("t2", 4, 0, 1, 2, 3);

    // 3: sparse enable mask.
    set_frame(4'b0101, 2);
    vs_fall();
    wait_idle("t3", 100);
    cycles(2);
    check_order("t3", 2, 0, 2, 0, 0);
    check("t3_cur", 32'(cur_task), 3);
    check("t3_cnt", 32'(frame_cnt), 2);

    // 4: second vsync while task 1 waits -> overrun, sequence completes.
    set_frame(4'hF, 3);
    vs_fall();
    begin
      int n;
      n = 0;
      while (exp_r.req != 4'b0010 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) check("t4_wait_task1", 1, 0);
    end
    vs_fall();
    wait_idle("t4", 100);
    cycles(2);
    check("t4_ovr", 32'(overrun), 1);
    check("t4_cnt", 32'(frame_cnt), 3);
    check_order("t4", 4, 0, 1, 2, 3);
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    cycles(1);
    check("t4_ovr_clr", 32'(overrun), 0);

    // 5: task 2 hangs for 40 cycles (watchdog fires at 8 when enabled).
    set_frame(4'hF, 2);
    dly[2] = 40;
    vs_fall();
    wait_idle("t5", 300);
    cycles(2);
    check_order("t5", 4, 0, 1, 2, 3);
`ifdef VBS_WATCHDOG_EN
    check("t5_req2_cycles", 32'(hi2), 8);
    check("t5_terr", 32'(timeout_err), 1);
`else
    check("t5_req2_cycles", 32'(hi2), 40);
    check("t5_terr", 32'(timeout_err), 0);
`endif
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    cycles(1);
    check("t5_terr_clr", 32'(timeout_err), 0);

    // 6: pause at the vsync edge ignores the frame; pause mid-sequence does not.
    set_frame(4'hF, 1);
    pause = 1'b1;
    vs_fall();
    cycles(6);
    check("t6_pause_cnt", 32'(frame_cnt), 4);
    check("t6_pause_ticks", 32'(ticks), 0);
    pause = 1'b0;
    vs_fall();
    pause = 1'b1;
    wait_idle("t6", 100);
    pause = 1'b0;
    cycles(2);
    check("t6_mid_cnt", 32'(frame_cnt), 5);
    check("t6_mid_dones", 32'(dones), 1);

    // all disabled: TICK, N slots, DONE, no grants.
    set_frame(4'h0, 1);
    vs_fall();
    wait_idle("t6b", 50);
    cycles(2);
    check("t6b_grants", 32'(obs_q.size()), 0);
    check("t6b_dones", 32'(dones), 1);

    // frame_cnt wrap 0xFFFF -> 0.
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cycles(2);
    release dut.frame_cnt;
    cycles(1);
    vs_fall();
    wait_idle("wrap", 50);
    cycles(1);
    check("wrap_cnt", 32'(frame_cnt), 0);

    // clr mid-WAIT drops the grant immediately.
    set_frame(4'hF, 5);
    vs_fall();
    begin
      int n;
      n = 0;
      while (exp_r.req == '0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("clr_wait_req", 1, 0);
    end
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr_async_req", 32'(task_req), 0);
    check("clr_async_busy", 32'(busy), 0);
    cycles(2);
    clr = 1'b0;
    cycles(3);

    // Random frames with noisy acks, stray vsync edges, pause and clear_err.
    noise_en = 1;
    for (int f = 0; f < 40; f++) begin
      task_en = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) dly[$urandom_range(0, N - 1)] = $urandom_range(7, 12);
      pause = ($urandom_range(0, 7) == 0);
      vs_fall();
      begin
        int n;
        n = 0;
        while (exp_r.busy && n < 400) begin
          @(negedge clk);
          vga_VS    = ($urandom_range(0, 11) != 0);
          pause     = ($urandom_range(0, 3) == 0);
          clear_err = ($urandom_range(0, 15) == 0);
          n++;
        end
      end
      vga_VS = 1'b1; pause = 1'b0; clear_err = 1'b0;
      cycles(1);
      wait_idle("rand", 400);
      cycles($urandom_range(1, 3));
    end

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
